// File: rtl/pipe_stage_reg_pkg.sv
// pipe_stage_reg_pkg: shared CPU constants, stall-vector stage indices and the stage action decode.
package pipe_stage_reg_pkg;
   localparam int CPU_XLEN    = 32;
   localparam int CPU_RADDR_W = 5;
   localparam int CPU_ALUOP_W = 8;
   localparam int CPU_ALUOP_NOP = 0;
   localparam int STG_EX = 3;
   localparam int STG_WB = 5;
   typedef enum logic [1:0] {ACT_LOAD, ACT_FLUSH, ACT_BUBBLE, ACT_HOLD} stage_act_e;
   // A stopped downstream always wins, so a flush waits until it releases.
   function automatic stage_act_e stage_action(input logic stop_up, input logic stop_dn, input logic flush);
      return stop_dn ? ACT_HOLD : flush ? ACT_FLUSH : stop_up ? ACT_BUBBLE : ACT_LOAD;
   endfunction
endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// sat_counter: saturating event counter with synchronous clear that overrides increment.
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_inc,
   input  logic             i_clr,
   output logic [CNT_W-1:0] o_cnt
);
   logic [CNT_W-1:0] r_cnt;
   always_ff @(posedge clk)
      if (rst || i_clr) r_cnt <= '0;
      else if (i_inc && !(&r_cnt)) r_cnt <= r_cnt + 1'b1;
   assign o_cnt = r_cnt;
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: inter-stage pipeline register with flush, bubble/stall statistics and a bypass port.
module pipe_stage_reg
   import pipe_stage_reg_pkg::*;
#(
   parameter int STAGE_IDX = STG_EX,
   parameter int STALL_W   = STG_WB + 1,
   parameter int XLEN      = CPU_XLEN,
   parameter int RADDR_W   = CPU_RADDR_W,
   parameter int ALUOP_W   = CPU_ALUOP_W,
   parameter int ALUOP_NOP = CPU_ALUOP_NOP,
   parameter int CNT_W     = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [STALL_W-1:0] i_stall,
   input  logic               i_flush,
   input  logic               i_stat_clr,
   input  logic               i_valid,
   input  logic [RADDR_W-1:0] i_wd,
   input  logic               i_wreg,
   input  logic [XLEN-1:0]    i_wdata,
   input  logic [ALUOP_W-1:0] i_aluop,
   input  logic [XLEN-1:0]    i_mem_addr,
   input  logic [XLEN-1:0]    i_reg2,
   input  logic [XLEN-1:0]    i_pc,
   input  logic               i_is_load,
   output logic               o_valid,
   output logic [RADDR_W-1:0] o_wd,
   output logic               o_wreg,
   output logic [XLEN-1:0]    o_wdata,
   output logic [ALUOP_W-1:0] o_aluop,
   output logic [XLEN-1:0]    o_mem_addr,
   output logic [XLEN-1:0]    o_reg2,
   output logic [XLEN-1:0]    o_pc,
   output logic               o_is_load,
   output logic               o_fwd_valid,
   output logic [RADDR_W-1:0] o_fwd_wd,
   output logic [XLEN-1:0]    o_fwd_wdata,
   output logic               o_fwd_load_busy,
   output logic [CNT_W-1:0]   o_stat_stalls,
   output logic [CNT_W-1:0]   o_stat_bubbles
);
   if (STAGE_IDX + 1 >= STALL_W) begin : g_bad_stage
      $error("pipe_stage_reg: STAGE_IDX+1 must be below STALL_W");
   end
   logic       w_s, w_s1, w_bub;
   stage_act_e w_act;
   logic               r_valid, r_wreg, r_is_load;
   logic [RADDR_W-1:0] r_wd;
   logic [XLEN-1:0]    r_wdata, r_mem_addr, r_reg2, r_pc;
   logic [ALUOP_W-1:0] r_aluop;
   assign w_s  = i_stall[STAGE_IDX];
   assign w_s1 = i_stall[STAGE_IDX+1];
   always_comb w_act = stage_action(w_s, w_s1, i_flush);
   // An empty upstream slot loads as a bubble but is not counted as one.
   assign w_bub = w_act == ACT_FLUSH || w_act == ACT_BUBBLE || (w_act == ACT_LOAD && !i_valid);
   always_ff @(posedge clk)
      if (rst || (w_act != ACT_HOLD && w_bub)) begin
         r_valid    <= 1'b0;
         r_wd       <= '0;
         r_wreg     <= 1'b0;
         r_wdata    <= '0;
         r_aluop    <= ALUOP_W'(ALUOP_NOP);
         r_mem_addr <= '0;
         r_reg2     <= '0;
         r_pc       <= '0;
         r_is_load  <= 1'b0;
      end else if (w_act == ACT_LOAD) begin
         r_valid    <= 1'b1;
         r_wd       <= i_wd;
         r_wreg     <= i_wreg;
         r_wdata    <= i_wdata;
         r_aluop    <= i_aluop;
         r_mem_addr <= i_mem_addr;
         r_reg2     <= i_reg2;
         r_pc       <= i_pc;
         r_is_load  <= i_is_load;
      end
   sat_counter #(.CNT_W(CNT_W)) u_stalls (
      .clk(clk), .rst(rst), .i_inc(w_act == ACT_HOLD), .i_clr(i_stat_clr), .o_cnt(o_stat_stalls)
   );
   sat_counter #(.CNT_W(CNT_W)) u_bubbles (
      .clk(clk), .rst(rst), .i_inc(w_act == ACT_FLUSH || w_act == ACT_BUBBLE), .i_clr(i_stat_clr),
      .o_cnt(o_stat_bubbles)
   );
   assign o_valid         = r_valid;
   assign o_wd            = r_wd;
   assign o_wreg          = r_wreg;
   assign o_wdata         = r_wdata;
   assign o_aluop         = r_aluop;
   assign o_mem_addr      = r_mem_addr;
   assign o_reg2          = r_reg2;
   assign o_pc            = r_pc;
   assign o_is_load       = r_is_load;
   assign o_fwd_valid     = r_valid && r_wreg && !r_is_load && r_wd != '0;
   assign o_fwd_wd        = r_wd;
   assign o_fwd_wdata     = r_wdata;
   assign o_fwd_load_busy = r_valid && r_is_load && r_wreg && r_wd != '0;
`ifndef SYNTHESIS
   // Downstream stopped while upstream runs would drop an instruction.
   a_stall_order: assert property (@(posedge clk) disable iff (rst) !(w_s1 && !w_s));
`endif
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: vector table, randomized model comparison and counter saturation checks.
module tb_pipe_stage_reg;
   logic clk = 1'b0, rst, flush, clr, valid, wreg, ld;
   logic [5:0] stall;
   logic [4:0] wd;
   logic [31:0] wdata, ma, r2, pc;
   logic [7:0] aluop;
   logic o_valid, o_wreg, o_ld, o_fv, o_busy;
   logic [4:0] o_wd, o_fwd_wd;
   logic [31:0] o_wdata, o_ma, o_r2, o_pc, o_fwd_wdata;
   logic [7:0] o_aluop;
   logic [15:0] o_st, o_bb;
   logic q_valid, q_wreg, q_ld, q_fv, q_busy;
   logic [4:0] q_wd, q_fwd_wd;
   logic [31:0] q_wdata, q_ma, q_r2, q_pc, q_fwd_wdata;
   logic [7:0] q_aluop;
   logic [1:0] q_st, q_bb;
   int total = 0, bad = 0;
   always #5 clk = ~clk;
   pipe_stage_reg u_dut (
      .clk(clk), .rst(rst), .i_stall(stall), .i_flush(flush), .i_stat_clr(clr), .i_valid(valid),
      .i_wd(wd), .i_wreg(wreg), .i_wdata(wdata), .i_aluop(aluop), .i_mem_addr(ma), .i_reg2(r2),
      .i_pc(pc), .i_is_load(ld), .o_valid(o_valid), .o_wd(o_wd), .o_wreg(o_wreg), .o_wdata(o_wdata),
      .o_aluop(o_aluop), .o_mem_addr(o_ma), .o_reg2(o_r2), .o_pc(o_pc), .o_is_load(o_ld),
      .o_fwd_valid(o_fv), .o_fwd_wd(o_fwd_wd), .o_fwd_wdata(o_fwd_wdata), .o_fwd_load_busy(o_busy),
      .o_stat_stalls(o_st), .o_stat_bubbles(o_bb)
   );
   pipe_stage_reg #(.CNT_W(2)) u_sat (
      .clk(clk), .rst(rst), .i_stall(stall), .i_flush(flush), .i_stat_clr(clr), .i_valid(valid),
      .i_wd(wd), .i_wreg(wreg), .i_wdata(wdata), .i_aluop(aluop), .i_mem_addr(ma), .i_reg2(r2),
      .i_pc(pc), .i_is_load(ld), .o_valid(q_valid), .o_wd(q_wd), .o_wreg(q_wreg), .o_wdata(q_wdata),
      .o_aluop(q_aluop), .o_mem_addr(q_ma), .o_reg2(q_r2), .o_pc(q_pc), .o_is_load(q_ld),
      .o_fwd_valid(q_fv), .o_fwd_wd(q_fwd_wd), .o_fwd_wdata(q_fwd_wdata), .o_fwd_load_busy(q_busy),
      .o_stat_stalls(q_st), .o_stat_bubbles(q_bb)
   );
   typedef struct {
      logic rst; logic [5:0] stall; logic flush, clr, valid; logic [4:0] wd; logic wreg, ld;
      logic [31:0] wdata;
      logic e_valid; logic [4:0] e_wd; logic [31:0] e_wdata; logic e_fv, e_busy; int e_st, e_bb;
   } vec_t;
   typedef struct {
      logic v; logic [4:0] wd; logic wreg; logic [31:0] wdata; logic [7:0] aluop;
      logic [31:0] ma, r2, pc; logic ld;
   } pay_t;
   vec_t vt[$];
   function automatic vec_t v(input logic r, input logic [5:0] s, input logic f, c, va,
                              input logic [4:0] w, input logic we, l, input logic [31:0] d,
                              input logic ev, input logic [4:0] ew, input logic [31:0] ed,
                              input logic efv, eb, input int est, ebb);
      vec_t x;
      x.rst = r; x.stall = s; x.flush = f; x.clr = c; x.valid = va; x.wd = w; x.wreg = we; x.ld = l;
      x.wdata = d; x.e_valid = ev; x.e_wd = ew; x.e_wdata = ed; x.e_fv = efv; x.e_busy = eb;
      x.e_st = est; x.e_bb = ebb;
      return x;
   endfunction
   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask
   task automatic drive(input vec_t x);
      rst = x.rst; stall = x.stall; flush = x.flush; clr = x.clr; valid = x.valid; wd = x.wd;
      wreg = x.wreg; ld = x.ld; wdata = x.wdata; pc = x.wdata ^ 32'h1000; ma = x.wdata + 32'd4;
      r2 = ~x.wdata; aluop = 8'h2a;
   endtask
   initial begin
      pay_t m;
      int mst, mbb;
      logic hold, kill;
      vt.push_back(v(1, 6'h3f, 1, 1, 1, 9, 1, 1, 32'hffff, 0, 0, 0, 0, 0, 0, 0));
      vt.push_back(v(1, 6'h3f, 1, 1, 1, 9, 1, 1, 32'hffff, 0, 0, 0, 0, 0, 0, 0));
      vt.push_back(v(0, 6'h00, 0, 0, 1, 5, 1, 0, 32'h1234, 1, 5, 32'h1234, 1, 0, 0, 0));
      vt.push_back(v(0, 6'h08, 0, 0, 1, 6, 1, 0, 32'h55, 0, 0, 0, 0, 0, 0, 1));
      vt.push_back(v(0, 6'h00, 0, 0, 1, 6, 1, 0, 32'h55, 1, 6, 32'h55, 1, 0, 0, 1));
      vt.push_back(v(0, 6'h18, 0, 0, 1, 7, 1, 0, 32'h99, 1, 6, 32'h55, 1, 0, 1, 1));
      vt.push_back(v(0, 6'h18, 0, 0, 0, 8, 0, 1, 32'haa, 1, 6, 32'h55, 1, 0, 2, 1));
      vt.push_back(v(0, 6'h18, 0, 0, 1, 9, 1, 0, 32'hbb, 1, 6, 32'h55, 1, 0, 3, 1));
      vt.push_back(v(0, 6'h00, 1, 0, 1, 8, 1, 1, 32'hcc, 0, 0, 0, 0, 0, 3, 2));
      vt.push_back(v(0, 6'h00, 0, 0, 1, 7, 1, 1, 32'ha, 1, 7, 32'ha, 0, 1, 3, 2));
      vt.push_back(v(0, 6'h18, 1, 0, 1, 9, 1, 0, 32'hb, 1, 7, 32'ha, 0, 1, 4, 2));
      vt.push_back(v(0, 6'h00, 1, 0, 1, 9, 1, 0, 32'hb, 0, 0, 0, 0, 0, 4, 3));
      vt.push_back(v(0, 6'h00, 0, 0, 1, 0, 1, 0, 32'h77, 1, 0, 32'h77, 0, 0, 4, 3));
      vt.push_back(v(0, 6'h18, 0, 1, 1, 3, 1, 0, 32'h5, 1, 0, 32'h77, 0, 0, 0, 0));
      vt.push_back(v(1, 6'h18, 0, 0, 1, 3, 1, 0, 32'h5, 0, 0, 0, 0, 0, 0, 0));
      vt.push_back(v(0, 6'h00, 0, 0, 0, 3, 1, 0, 32'h42, 0, 0, 0, 0, 0, 0, 0));
      vt.push_back(v(0, 6'h08, 0, 1, 1, 2, 1, 0, 32'h9, 0, 0, 0, 0, 0, 0, 0));
      foreach (vt[i]) begin
         drive(vt[i]);
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d.valid", i), 64'(o_valid), 64'(vt[i].e_valid));
         chk($sformatf("vec%0d.wd", i), 64'(o_wd), 64'(vt[i].e_wd));
         chk($sformatf("vec%0d.wdata", i), 64'(o_wdata), 64'(vt[i].e_wdata));
         chk($sformatf("vec%0d.aluop", i), 64'(o_aluop), vt[i].e_valid ? 64'h2a : 64'h0);
         chk($sformatf("vec%0d.pc", i), 64'(o_pc), vt[i].e_valid ? 64'(vt[i].e_wdata ^ 32'h1000) : 64'h0);
         chk($sformatf("vec%0d.fwd_valid", i), 64'(o_fv), 64'(vt[i].e_fv));
         chk($sformatf("vec%0d.fwd_wd", i), 64'(o_fwd_wd), 64'(vt[i].e_wd));
         chk($sformatf("vec%0d.load_busy", i), 64'(o_busy), 64'(vt[i].e_busy));
         chk($sformatf("vec%0d.stalls", i), 64'(o_st), 64'(vt[i].e_st));
         chk($sformatf("vec%0d.bubbles", i), 64'(o_bb), 64'(vt[i].e_bb));
      end
      m = '{default: '0};
      mst = 0;
      mbb = 0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      for (int n = 0; n < 400; n++) begin
         rst = $urandom_range(0, 39) == 0;
         stall = 6'($urandom);
         stall[4] = $urandom_range(0, 3) == 0;
         stall[3] = stall[4] | ($urandom_range(0, 4) == 0);
         flush = $urandom_range(0, 5) == 0;
         clr = $urandom_range(0, 19) == 0;
         valid = $urandom_range(0, 3) != 0;
         wd = $urandom_range(0, 3) == 0 ? 5'd0 : 5'($urandom);
         wreg = 1'($urandom);
         ld = 1'($urandom);
         wdata = $urandom; aluop = 8'($urandom); ma = $urandom; r2 = $urandom; pc = $urandom;
         if (rst) begin
            m = '{default: '0};
            mst = 0;
            mbb = 0;
         end else begin
            hold = stall[4];
            kill = !hold && (flush || stall[3]);
            if (!hold) m = (kill || !valid) ? '{default: '0} : '{1'b1, wd, wreg, wdata, aluop, ma, r2, pc, ld};
            mst = clr ? 0 : hold ? (mst < 65535 ? mst + 1 : mst) : mst;
            mbb = clr ? 0 : kill ? (mbb < 65535 ? mbb + 1 : mbb) : mbb;
         end
         @(posedge clk);
         #1;
         chk($sformatf("rnd%0d.valid", n), 64'(o_valid), 64'(m.v));
         chk($sformatf("rnd%0d.payload", n),
             {o_wd, o_wreg, o_ld, o_aluop, o_wdata, 17'(o_pc)},
             {m.wd, m.wreg, m.ld, m.aluop, m.wdata, 17'(m.pc)});
         chk($sformatf("rnd%0d.ma_r2", n), {o_ma, o_r2}, {m.ma, m.r2});
         chk($sformatf("rnd%0d.fwd", n), {62'(o_fwd_wd), o_fv, o_busy},
             {62'(m.wd), m.v & m.wreg & ~m.ld & (m.wd != 0), m.v & m.ld & m.wreg & (m.wd != 0)});
         chk($sformatf("rnd%0d.fwd_wdata", n), 64'(o_fwd_wdata), 64'(m.wdata));
         chk($sformatf("rnd%0d.stats", n), {32'(o_st), 32'(o_bb)}, {32'(mst), 32'(mbb)});
      end
      drive(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      @(posedge clk);
      #1;
      chk("sat.reset", 64'(q_st), 64'h0);
      for (int k = 1; k <= 5; k++) begin
         drive(v(0, 6'h18, 0, 0, 1, 4, 1, 0, 32'h1, 0, 0, 0, 0, 0, 0, 0));
         @(posedge clk);
         #1;
         chk($sformatf("sat.hold%0d", k), 64'(q_st), 64'(k < 3 ? k : 3));
      end
      drive(v(0, 6'h18, 0, 1, 1, 4, 1, 0, 32'h1, 0, 0, 0, 0, 0, 0, 0));
      @(posedge clk);
      #1;
      chk("sat.clr_inc", 64'(q_st), 64'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
